am2918_reg: RTL and testbench
=============================

AM2918_REG -- requirements
Module: Am2918

Interface
REQ-001 Parameter: WIDTH, 4, data width of D, Q and Y; all requirements below use the default 4.
REQ-002 CP  input  1  rising-edge clock for the data register.
REQ-003 RST  input  1  reset, asynchronous, active-high; clears the register.
REQ-004 D  input  WIDTH  parallel data input.
REQ-005 OE  input  1  output enable for Y, active-low (/OE).
REQ-006 Q  output  WIDTH  standard (always-driven) register output.
REQ-007 Y  output  WIDTH  three-state register output.
REQ-008 Port order SHALL be D, CP, OE, Q, Y, RST, so existing positional instantiations (D, CP, OE, Q, Y) remain valid.
REQ-009 The block SHALL have one clock (CP) and an asynchronous, active-high reset (RST); the polarity and synchronicity are fixed.

Function
REQ-010 The block SHALL contain one WIDTH-bit register R, loaded from D on every rising edge of CP while RST is low.
REQ-011 Load latency SHALL be zero cycles: Q equals the D value sampled at the most recent CP rising edge.
REQ-012 Changes on D between CP rising edges SHALL NOT affect R, Q or Y.
REQ-013 Q SHALL continuously drive R and SHALL be independent of OE.
REQ-014 Y SHALL drive R when OE=0 and SHALL be high-impedance (all bits z) when OE=1.
REQ-015 The OE to Y transition SHALL be purely combinational and asynchronous to CP; no clock edge is needed.
REQ-016 OE SHALL NOT modify R: toggling OE 0->1->0 SHALL restore Y to the unchanged R value.
REQ-017 All bits SHALL load simultaneously; there is no enable, shift or hold mode other than reset.
REQ-018 If a CP rising edge coincides with RST high, reset SHALL win and R SHALL be 0.

Reset
REQ-019 While RST=1, R SHALL be 0 immediately, regardless of CP; Q=0, and Y=0 if OE=0, else z.
REQ-020 On RST deassertion, the first CP rising edge with RST low SHALL load D.
REQ-021 R SHALL start at 0 in simulation, so Q=0 before any reset or clock edge.
REQ-022 An unconnected RST SHALL be treated as inactive.

Verification
REQ-023 D=0000, OE=0, one CP rising edge -> Q=0000, Y=0000.
REQ-024 D=0000 loaded, then D=1111, then CP rising edge -> Q=1111, Y=1111.
REQ-025 D=0000 loaded, then D=1111 with no CP edge -> Q=0000, Y=0000.
REQ-026 R=0000, OE=1, check 5 ns later -> Q=0000, Y=zzzz.
REQ-027 Load 1111, then OE=1 for 20 ns, then OE=0, check 5 ns later -> Q=1111, Y=1111.
REQ-028 Load 1010, then RST=1 between clock edges -> Q=0000 at once; RST=0, D=0101, CP edge -> Q=0101.

Source files
------------

// File: rtl/am2918_reg.sv
// Am2918-style data register: one WIDTH-bit register loaded on every rising
// CP edge, with an always-driven output Q and a three-state output Y gated
// by the active-low output enable OE.
module am2918_reg #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] D,
  input  logic             CP,
  input  logic             OE,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Y,
  // Pulled low so a left-open reset pin reads as inactive.
  input  tri0              RST
);

  // Power-up value keeps Q at zero before the first reset or clock edge.
  logic [WIDTH-1:0] r = '0;

  // Load all bits from D on every clock edge; reset clears at once and wins over CP.
  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      r <= '0;
    end else begin
      r <= D;
    end
  end

  // Q always reflects the register, regardless of OE.
  assign Q = r;

  // Y follows the register when OE is low and floats when OE is high.
  assign Y = OE ? 'z : r;

endmodule

// File: tb/tb_am2918_reg.sv
// Directed bench for am2918_reg: load behaviour, hold between edges,
// three-state Y control and asynchronous reset.
`timescale 1ns/1ps
module tb_am2918_reg;

  logic       cp;
  logic       rst;
  logic       oe;
  logic [3:0] d;
  wire  [3:0] q;
  wire  [3:0] y;

  int unsigned compared = 0;
  int unsigned mismatched = 0;

  am2918_reg #(.WIDTH(4)) dut (
    .D  (d),
    .CP (cp),
    .OE (oe),
    .Q  (q),
    .Y  (y),
    .RST(rst)
  );

  initial cp = 1'b0;
  always #5 cp = ~cp;

  // Compare a driven value against its expected pattern.
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Wait for the next rising edge, then step clear of it before driving or sampling.
  task automatic tick();
    @(posedge cp);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    oe  = 1'b0;
    d   = 4'b0000;

    // Power-up state, before any clock edge or reset
    #1;
    chk("powerup_q", q, 4'b0000);
    chk("powerup_y", y, 4'b0000);

    // Load zero
    tick();
    chk("load0_q", q, 4'b0000);
    chk("load0_y", y, 4'b0000);

    // D changes with no edge: register holds
    d = 4'b1111;
    #2;
    chk("hold_q", q, 4'b0000);
    chk("hold_y", y, 4'b0000);

    // Edge loads the new value
    tick();
    chk("load1111_q", q, 4'b1111);
    chk("load1111_y", y, 4'b1111);

    // Another pattern, then mid-cycle D change must not leak through
    d = 4'b0110;
    tick();
    chk("load0110_q", q, 4'b0110);
    d = 4'b1001;
    #3;
    chk("midcycle_q", q, 4'b0110);
    chk("midcycle_y", y, 4'b0110);

    // Return to zero, then disable Y: Q stays driven, Y floats
    d = 4'b0000;
    tick();
    chk("zero_q", q, 4'b0000);
    oe = 1'b1;
    #5;
    chk("oe1_q", q, 4'b0000);
    compared++;
    assert (y === 4'bzzzz)
    else begin
      mismatched++;
      $error("FAIL oe1_y_z observed=%b expected=zzzz", y);
    end

    // Load 1111 with OE high, hold OE high 20 ns, then re-enable
    d = 4'b1111;
    tick();
    chk("oe_hidden_q", q, 4'b1111);
    #20;
    compared++;
    assert (y === 4'bzzzz)
    else begin
      mismatched++;
      $error("FAIL oe_hidden_y_z observed=%b expected=zzzz", y);
    end
    oe = 1'b0;
    #5;
    chk("oe_restore_q", q, 4'b1111);
    chk("oe_restore_y", y, 4'b1111);

    // Load 1010, then reset mid-cycle: clears without a clock edge
    d = 4'b1010;
    tick();
    chk("load1010_q", q, 4'b1010);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_q", q, 4'b0000);
    chk("rst_async_y", y, 4'b0000);

    // Reset held across a clock edge: reset wins over D
    tick();
    chk("rst_over_edge_q", q, 4'b0000);

    // During reset with OE high, Y floats
    oe = 1'b1;
    #1;
    compared++;
    assert (y === 4'bzzzz)
    else begin
      mismatched++;
      $error("FAIL rst_oe1_y_z observed=%b expected=zzzz", y);
    end
    oe = 1'b0;

    // Release reset; first edge loads D
    rst = 1'b0;
    d = 4'b0101;
    #1;
    chk("rst_release_q", q, 4'b0000);
    tick();
    chk("post_rst_q", q, 4'b0101);
    chk("post_rst_y", y, 4'b0101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
